// File: rtl/lsc_i2cs_config.sv
// rtl/lsc_i2cs_config.sv - I2C target with two RW config registers and a read-only status/result window
//
// Ports:
//   clk          core clock, at least 16x the SCL rate
//   reset        synchronous active-high reset
//   scl_in       I2C clock pad level (asynchronous)
//   sda_in       I2C data pad level (asynchronous)
//   sda_out      1 releases SDA, 0 pulls SDA low
//   o_config_00  register 0x00 (RW)
//   o_config_01  register 0x01 (RW)
//   i_status     read-only status at register 0x02
//   i_result     read-only result at 0x03 (high byte) / 0x04 (low byte)
//   o_wr_stb     one-clk pulse per accepted write to 0x00/0x01
//   o_busy       high from an address match until STOP or START
module lsc_i2cs_config #(
    parameter logic [6:0] I2C_ADDR = 7'h24,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic [7:0]  o_config_00,
    output logic [7:0]  o_config_01,
    input  logic [7:0]  i_status,
    input  logic [15:0] i_result,
    output logic        o_wr_stb,
    output logic        o_busy
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA, RDATA, ACK_RDATA
    } state_t;

    // Synchronizers and glitch filters; everything downstream sees only scl_f/sda_f.
    logic [1:0]    scl_sync, sda_sync;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_f, sda_f, scl_d, sda_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            // A level change is accepted only after FILT_LEN consecutive differing samples.
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_cnt <= '0;
                scl_f   <= scl_sync[1];
            end else begin
                scl_cnt <= scl_cnt + CW'(1);
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_cnt <= '0;
                sda_f   <= sda_sync[1];
            end else begin
                sda_cnt <= sda_cnt + CW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_f & ~scl_d;
    assign scl_fall  = ~scl_f &  scl_d;
    assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
    assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  ptr, ptr_n;
    logic        rw, rw_n;
    logic        host_ack, host_ack_n;
    logic        sda_n, busy_n, stb_n;
    logic [7:0]  cfg0_n, cfg1_n;
    logic [15:0] snap, snap_n;
    logic [2:0]  ld_ptr;
    logic [7:0]  rd_byte;
    logic        ld_snap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            host_ack    <= 1'b1;
            sda_out     <= 1'b1;
            o_busy      <= 1'b0;
            o_wr_stb    <= 1'b0;
            o_config_00 <= '0;
            o_config_01 <= '0;
            snap        <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            ptr         <= ptr_n;
            rw          <= rw_n;
            host_ack    <= host_ack_n;
            sda_out     <= sda_n;
            o_busy      <= busy_n;
            o_wr_stb    <= stb_n;
            o_config_00 <= cfg0_n;
            o_config_01 <= cfg1_n;
            snap        <= snap_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ptr_n      = ptr;
        rw_n       = rw;
        host_ack_n = host_ack;
        sda_n      = sda_out;
        busy_n     = o_busy;
        stb_n      = 1'b0;
        cfg0_n     = o_config_00;
        cfg1_n     = o_config_01;
        snap_n     = snap;

        // Byte to preload for reading: first byte of a read comes from ptr, later ones from ptr+1.
        // 0x04 reached by incrementing from 0x03 reuses the snapshot taken for 0x03.
        ld_ptr  = (state == ACK_RDATA) ? ptr + 3'd1 : ptr;
        ld_snap = 1'b0;
        case (ld_ptr)
            3'd0:    rd_byte = o_config_00;
            3'd1:    rd_byte = o_config_01;
            3'd2:    rd_byte = i_status;
            3'd3:    begin rd_byte = i_result[15:8]; ld_snap = 1'b1; end
            3'd4:    begin
                if (state == ACK_RDATA) begin
                    rd_byte = snap[7:0];
                end else begin
                    rd_byte = i_result[7:0];
                    ld_snap = 1'b1;
                end
            end
            default: rd_byte = 8'h00;
        endcase

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shreg[7:1] == I2C_ADDR) begin
                                state_n = ACK_ADDR;
                                sda_n   = 1'b0;
                                rw_n    = shreg[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == REG) begin
                            ptr_n   = shreg[2:0];
                            state_n = ACK_REG;
                            sda_n   = 1'b0;
                        end else begin
                            if (ptr == 3'd0) begin
                                cfg0_n = shreg;
                                stb_n  = 1'b1;
                            end else if (ptr == 3'd1) begin
                                cfg1_n = shreg;
                                stb_n  = 1'b1;
                            end
                            ptr_n   = ptr + 3'd1;
                            state_n = ACK_WDATA;
                            sda_n   = 1'b0;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_n = RDATA;
                            shreg_n = rd_byte;
                            sda_n   = rd_byte[7];
                            if (ld_snap) snap_n = i_result;
                        end else begin
                            state_n = REG;
                            sda_n   = 1'b1;
                        end
                    end
                end
                ACK_REG, ACK_WDATA: begin
                    if (scl_fall) begin
                        state_n = WDATA;
                        sda_n   = 1'b1;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n   = ACK_RDATA;
                            bit_cnt_n = '0;
                            sda_n     = 1'b1;
                        end else begin
                            sda_n   = shreg[6];
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    end
                end
                ACK_RDATA: begin
                    if (scl_rise) begin
                        host_ack_n = sda_f;
                    end else if (scl_fall) begin
                        if (!host_ack) begin
                            ptr_n   = ld_ptr;
                            state_n = RDATA;
                            shreg_n = rd_byte;
                            sda_n   = rd_byte[7];
                            if (ld_snap) snap_n = i_result;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
